// File: rtl/jam_pkg.sv
// jam_pkg: shared sizing, result-register init value and the FSM state type
// for the JAM sequencing controller (jam_sched) and its cost adder (jam_cost_sum).
package jam_pkg;
   localparam int N   = 8;              // workers == jobs
   localparam int IW  = 3;              // worker/job index width
   localparam int CW  = 7;              // cost entry width
   localparam int SW  = 10;             // total-cost width, holds N*(2^CW-1)
   localparam int MCW = 4;              // saturating match-count width

   localparam logic [SW-1:0] MIN_INIT = '1;

   typedef enum logic [2:0] {
      ST_LOAD,
      ST_REQ,
      ST_WAIT,
      ST_EVAL,
      ST_DONE,
      ST_HOLD
   } state_t;
endpackage

// File: rtl/jam_cost_sum.sv
// jam_cost_sum: combinational total cost of one assignment.
//   cost : N*N cost matrix, entry {w,j} = cost of worker w doing job j
//   perm : job index for worker i at [i]
//   sum  : zero-extended sum of cost[i][perm[i]] over all workers
// The adder tree is laid out heap-style (node k = node 2k + node 2k+1,
// leaves at N..2N-1), which is balanced for power-of-two N.
module jam_cost_sum
   import jam_pkg::*;
(
   input  logic [N*N-1:0][CW-1:0] cost,
   input  logic [N-1:0][IW-1:0]   perm,
   output logic [SW-1:0]          sum
);

   logic [SW-1:0] node [1:2*N-1];

   genvar i;
   generate
      for (i = 0; i < N; i++) begin : g_leaf
         localparam logic [IW-1:0] ROW = IW'(i);
         assign node[N+i] = {{(SW-CW){1'b0}}, cost[{ROW, perm[i]}]};
      end
      for (i = 1; i < N; i++) begin : g_node
         assign node[i] = node[2*i] + node[2*i+1];
      end
   endgenerate

   assign sum = node[1];

endmodule

// File: rtl/jam_sched.sv
// jam_sched: sequencing controller for the job-assignment datapath.
// Loads the N x N cost matrix through the W/J/Cost port (row-major, one
// entry per cycle), then requests permutations one at a time, evaluates each
// total cost and tracks the minimum and how many permutations reach it.
// Ports:
//   CLK, RST          clock, synchronous active-high reset
//   W, J, Cost        cost-matrix read port (Cost is valid for current W/J)
//   perm_req          one-cycle request for the next permutation
//   perm_valid/data/last  permutation response, only sampled in WAIT
//   MinCost, MatchCount   results; Valid pulses one cycle when final
module jam_sched
   import jam_pkg::*;
(
   input  logic            CLK,
   input  logic            RST,
   output logic [IW-1:0]   W,
   output logic [IW-1:0]   J,
   input  logic [CW-1:0]   Cost,
   output logic            perm_req,
   input  logic            perm_valid,
   input  logic [IW*N-1:0] perm_data,
   input  logic            perm_last,
   output logic [MCW-1:0]  MatchCount,
   output logic [SW-1:0]   MinCost,
   output logic            Valid
);

   localparam logic [IW-1:0] LAST_IDX = IW'(N-1);

   state_t                  state, state_nxt;
   logic [N*N-1:0][CW-1:0]  cost_mem;
   logic [N-1:0][IW-1:0]    perm_q;
   logic                    last_q;
   logic [SW-1:0]           sum;
   logic                    load_end;

   assign load_end = (W == LAST_IDX) && (J == LAST_IDX);

   jam_cost_sum u_sum (
      .cost (cost_mem),
      .perm (perm_q),
      .sum  (sum)
   );

   // Matrix storage is not reset; a reload always rewrites every entry.
   always_ff @(posedge CLK) begin
      if (!RST && state == ST_LOAD)
         cost_mem[{W, J}] <= Cost;
   end

   always_ff @(posedge CLK) begin
      if (RST) state <= ST_LOAD;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      perm_req  = 1'b0;
      Valid     = 1'b0;
      unique case (state)
         ST_LOAD: if (load_end) state_nxt = ST_REQ;
         ST_REQ: begin
            perm_req  = 1'b1;
            state_nxt = ST_WAIT;
         end
         ST_WAIT: if (perm_valid) state_nxt = ST_EVAL;
         ST_EVAL: state_nxt = last_q ? ST_DONE : ST_REQ;
         ST_DONE: begin
            Valid     = 1'b1;
            state_nxt = ST_HOLD;
         end
         ST_HOLD: state_nxt = ST_HOLD;
         default: state_nxt = ST_LOAD;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         W          <= '0;
         J          <= '0;
         perm_q     <= '0;
         last_q     <= 1'b0;
         MinCost    <= MIN_INIT;
         MatchCount <= '0;
      end else begin
         // W/J stop at the last entry and stay there until the next reset.
         if (state == ST_LOAD && !load_end) begin
            if (J == LAST_IDX) begin
               J <= '0;
               W <= W + 1'b1;
            end else begin
               J <= J + 1'b1;
            end
         end

         if (state == ST_WAIT && perm_valid) begin
            perm_q <= perm_data;
            last_q <= perm_last;
         end

         if (state == ST_EVAL) begin
            if (sum < MinCost) begin
               MinCost    <= sum;
               MatchCount <= MCW'(1);
            end else if (sum == MinCost && MatchCount != '1) begin
               MatchCount <= MatchCount + 1'b1;
            end
         end
      end
   end

endmodule
